// File: rtl/ipg_pkg.sv
// Shared types and default field widths for the IPG write-request assembler.
package ipg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam int HDR_WIDTH_DEF = 16;
    localparam int ADR_WIDTH_DEF = 40;

endpackage

// File: rtl/ipg_bit_packer.sv
// Inserts the top min(len, remaining) bits of a beat MSB-first into the payload
// buffer, directly below the bits already collected, and returns the new remaining count.
module ipg_bit_packer #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 16,
    parameter int PAYLOAD_LEN = 512,
    parameter int LEN_W       = $clog2(DATA_WIDTH + 1)
) (
    input  logic [PAYLOAD_LEN-1:0] buf_in,
    input  logic [HDR_WIDTH-1:0]   remaining_in,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [LEN_W-1:0]       len,
    output logic [PAYLOAD_LEN-1:0] buf_out,
    output logic [HDR_WIDTH-1:0]   remaining_out
);
    // Wide enough that neither the aligned field nor its shifted copy can overflow.
    localparam int W = PAYLOAD_LEN + DATA_WIDTH;

    logic [HDR_WIDTH-1:0] take;
    logic [HDR_WIDTH-1:0] base;
    logic [W-1:0]         field;
    logic [W-1:0]         mask;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        take          = (HDR_WIDTH'(len) < remaining_in) ? HDR_WIDTH'(len) : remaining_in;
        base          = remaining_in - take;
        field         = W'(data) >> (DATA_WIDTH - 32'(take));
        mask          = (W'(1) << take) - W'(1);
        buf_out       = PAYLOAD_LEN'((W'(buf_in) & ~(mask << base)) | ((field & mask) << base));
        remaining_out = remaining_in - take;
    end

endmodule

// File: rtl/ipg_wreq_assembler.sv
// Assembles header + payload beats into one memory write request.
// Optional idle-beat abort in COLLECT is enabled with macro IPG_WREQ_TIMEOUT_EN.
module ipg_wreq_assembler
    import ipg_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int HDR_WIDTH      = HDR_WIDTH_DEF,
    parameter int ADR_WIDTH      = ADR_WIDTH_DEF,
    parameter int PAYLOAD_LEN    = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           rx_ipg_data,
    input  logic [$clog2(DATA_WIDTH+1)-1:0] rx_len,
    input  logic                            wreq_valid,
    output logic                            mem_wr_valid,
    input  logic                            mem_wr_ready,
    output logic [ADR_WIDTH-1:0]            mem_wr_addr,
    output logic [PAYLOAD_LEN-1:0]          mem_wr_data,
    output logic [HDR_WIDTH-1:0]            mem_wr_len,
    output logic                            busy,
    output logic                            err_len,
    output logic                            err_hdr,
    output logic                            err_drop
);
    localparam int LEN_W = $clog2(DATA_WIDTH + 1);

    state_t                 state;
    logic [PAYLOAD_LEN-1:0] payload;
    logic [HDR_WIDTH-1:0]   remaining;

    logic [LEN_W-1:0]       len_eff;
    logic                   beat;
    logic                   hdr_short;
    logic                   hdr_len_bad;
    logic [HDR_WIDTH-1:0]   hdr_len;
    logic [ADR_WIDTH-1:0]   hdr_addr;
    logic [PAYLOAD_LEN-1:0] packed_payload;
    logic [HDR_WIDTH-1:0]   packed_remaining;
    logic                   timeout;

    always_comb begin
        len_eff     = (32'(rx_len) > DATA_WIDTH) ? LEN_W'(DATA_WIDTH) : rx_len;
        beat        = wreq_valid && (rx_len != '0);
        hdr_len     = rx_ipg_data[DATA_WIDTH-1 -: HDR_WIDTH];
        hdr_addr    = rx_ipg_data[DATA_WIDTH-HDR_WIDTH-1 -: ADR_WIDTH];
        hdr_short   = 32'(len_eff) < (HDR_WIDTH + ADR_WIDTH);
        hdr_len_bad = (hdr_len == '0) || (32'(hdr_len) > PAYLOAD_LEN);
    end

    ipg_bit_packer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HDR_WIDTH   (HDR_WIDTH),
        .PAYLOAD_LEN (PAYLOAD_LEN),
        .LEN_W       (LEN_W)
    ) u_packer (
        .buf_in        (payload),
        .remaining_in  (remaining),
        .data          (rx_ipg_data),
        .len           (len_eff),
        .buf_out       (packed_payload),
        .remaining_out (packed_remaining)
    );

`ifdef IPG_WREQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt;

    // Counts consecutive beat-less COLLECT cycles; fires on the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk) begin
        if (reset || (state != COLLECT) || beat) idle_cnt <= '0;
        else                                      idle_cnt <= idle_cnt + CNT_W'(1);
    end

    assign timeout = (state == COLLECT) && !beat && (32'(idle_cnt) == TIMEOUT_CYCLES - 1);
`else
    // Abort disabled: the limit only participates as a constant that is never true.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // NOTE: state is updated with non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            payload      <= '0;
            remaining    <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_len   <= '0;
            busy         <= 1'b0;
            err_len      <= 1'b0;
            err_hdr      <= 1'b0;
            err_drop     <= 1'b0;
        end else begin
            err_len  <= 1'b0;
            err_hdr  <= 1'b0;
            err_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat) begin
                        if (hdr_short) begin
                            err_hdr <= 1'b1;
                        end else if (hdr_len_bad) begin
                            err_len <= 1'b1;
                        end else begin
                            payload     <= '0;
                            remaining   <= hdr_len;
                            mem_wr_addr <= hdr_addr;
                            mem_wr_len  <= hdr_len;
                            busy        <= 1'b1;
                            state       <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (timeout) begin
                        payload <= '0;
                        busy    <= 1'b0;
                        err_len <= 1'b1;
                        state   <= IDLE;
                    end else if (beat) begin
                        payload   <= packed_payload;
                        remaining <= packed_remaining;
                        if (packed_remaining == '0) begin
                            mem_wr_valid <= 1'b1;
                            state        <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Beats are never buffered here, even on the handshake cycle.
                    if (beat) err_drop <= 1'b1;
                    if (mem_wr_ready) begin
                        mem_wr_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_wr_data = payload;

endmodule

// File: tb/tb_ipg_wreq_assembler.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-queue model.
module tb_ipg_wreq_assembler;

    localparam int DW = 64;
    localparam int HW = 16;
    localparam int AW = 40;
    localparam int PL = 512;
`ifdef IPG_WREQ_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_ipg_data;
    logic [6:0]    rx_len;
    logic          wreq_valid;
    logic          mem_wr_valid;
    logic          mem_wr_ready;
    logic [AW-1:0] mem_wr_addr;
    logic [PL-1:0] mem_wr_data;
    logic [HW-1:0] mem_wr_len;
    logic          busy, err_len, err_hdr, err_drop;

    ipg_wreq_assembler #(
        .DATA_WIDTH(DW), .HDR_WIDTH(HW), .ADR_WIDTH(AW),
        .PAYLOAD_LEN(PL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_ipg_data(rx_ipg_data), .rx_len(rx_len),
        .wreq_valid(wreq_valid), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_len(mem_wr_len),
        .busy(busy), .err_len(err_len), .err_hdr(err_hdr), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [PL-1:0] got, input logic [PL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 waiting for header, 1 gathering payload bits, 2 offering the write.
    int            m_mode = 0;
    int            m_want = 0;
    int            m_idle = 0;
    bit            m_bits[$];
    bit            e_len, e_hdr, e_drop;
    logic [AW-1:0] e_addr = '0;
    logic [HW-1:0] e_lenv = '0;
    logic [PL-1:0] e_data = '0;
    bit            data_known = 1'b1;

    task automatic model_step(input bit v, input int l, input logic [DW-1:0] d,
                              input bit rdy, input bit rst);
        int n, take, hl;
        bit b;
        e_len = 0; e_hdr = 0; e_drop = 0;
        if (rst) begin
            m_mode = 0; m_idle = 0; m_bits.delete();
            e_addr = '0; e_lenv = '0; e_data = '0; data_known = 1;
            return;
        end
        n = (l > DW) ? DW : l;
        b = v && (l > 0);
        case (m_mode)
            0: if (b) begin
                if (n < HW + AW) e_hdr = 1;
                else begin
                    hl = int'(d[DW-1 -: HW]);
                    if (hl == 0 || hl > PL) e_len = 1;
                    else begin
                        m_want = hl; e_addr = d[DW-HW-1 -: AW]; e_lenv = HW'(hl);
                        m_bits.delete(); m_idle = 0; m_mode = 1; data_known = 0;
                    end
                end
            end
            1: if (b) begin
                m_idle = 0;
                take = (n < m_want - m_bits.size()) ? n : m_want - m_bits.size();
                for (int i = 0; i < take; i++) m_bits.push_back(d[DW-1-i]);
                if (m_bits.size() == m_want) begin
                    e_data = '0;
                    foreach (m_bits[k]) e_data[m_want-1-k] = m_bits[k];
                    data_known = 1; m_mode = 2;
                end
            end else begin
                m_idle++;
`ifdef IPG_WREQ_TIMEOUT_EN
                if (m_idle == TO) begin
                    m_mode = 0; e_len = 1; m_bits.delete(); e_data = '0; data_known = 1;
                end
`endif
            end
            default: begin
                if (b) e_drop = 1;
                if (rdy) m_mode = 0;
            end
        endcase
    endtask

    // One clock: drive inputs, let the DUT sample them, advance the model, compare at negedge.
    task automatic cycle(input bit v, input int l, input logic [DW-1:0] d,
                         input bit rdy, input bit rst);
        wreq_valid = v; rx_len = 7'(l); rx_ipg_data = d; mem_wr_ready = rdy; reset = rst;
        @(posedge clk);
        model_step(v, l, d, rdy, rst);
        @(negedge clk);
        check("busy", busy, (m_mode != 0));
        check("mem_wr_valid", mem_wr_valid, (m_mode == 2));
        check("err_len", err_len, e_len);
        check("err_hdr", err_hdr, e_hdr);
        check("err_drop", err_drop, e_drop);
        check("mem_wr_addr", mem_wr_addr, e_addr);
        check("mem_wr_len", mem_wr_len, e_lenv);
        if (data_known) check("mem_wr_data", mem_wr_data, e_data);
    endtask

    function automatic logic [DW-1:0] hdr(input int len, input logic [AW-1:0] a);
        return {HW'(len), a, 8'h5A};
    endfunction

    logic [DW-1:0] b1, b2, rd;
    logic [99:0]   e39;
    int            drops;
    bit            rv, rrst, rrdy;
    int            rl;

    initial begin
        reset = 1; wreq_valid = 0; rx_len = '0; rx_ipg_data = '0; mem_wr_ready = 0;
        @(negedge clk);
        cycle(0, 0, '0, 0, 1);
        check("reset_data", mem_wr_data, '0);
        cycle(0, 0, '0, 0, 0);

        // 16-bit payload
        cycle(1, 56, hdr(16, 40'h12_3456_789A), 0, 0);
        cycle(1, 16, {16'hBEEF, 48'h0123_4567_89AB}, 0, 0);
        check("t038_valid", mem_wr_valid, 1);
        check("t038_data", mem_wr_data, 512'hBEEF);
        check("t038_addr", mem_wr_addr, 40'h12_3456_789A);
        check("t038_len", mem_wr_len, 16);
        cycle(0, 0, '0, 1, 0);
        check("t038_after", mem_wr_valid, 0);

        // 100-bit payload, surplus bits of the second beat discarded
        b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        cycle(1, 64, hdr(100, 40'hAB_CDEF_0123), 0, 0);
        cycle(1, 64, b1, 0, 0);
        cycle(1, 64, b2, 0, 0);
        e39 = {b1, b2[63:28]};
        check("t039_data", mem_wr_data, PL'(e39));
        cycle(0, 0, '0, 1, 0);

        // zero and oversize lengths
        cycle(1, 64, hdr(0, 40'h1), 1, 0);
        check("t040_len0", err_len, 1);
        cycle(1, 64, hdr(513, 40'h2), 1, 0);
        check("t040_len513", err_len, 1);
        check("t040_nowrite", mem_wr_valid, 0);
        cycle(0, 0, '0, 1, 0);

        // backpressure with a beat during FLUSH
        cycle(1, 64, hdr(64, 40'h33), 0, 0);
        cycle(1, 64, {$urandom, $urandom}, 0, 0);
        drops = 0;
        for (int i = 0; i < 5; i++) begin
            cycle((i == 1), 64, {$urandom, $urandom}, 0, 0);
            if (err_drop) drops++;
        end
        check("t041_drops", drops, 1);
        cycle(0, 0, '0, 1, 0);
        check("t041_done", mem_wr_valid, 0);

        // reset with 64 bits still outstanding, then a fresh request
        cycle(1, 64, hdr(128, 40'h44), 0, 0);
        cycle(1, 64, {$urandom, $urandom}, 0, 0);
        cycle(0, 0, '0, 0, 1);
        check("t042_busy", busy, 0);
        cycle(1, 64, hdr(32, 40'h55), 0, 0);
        cycle(1, 40, {32'hCAFE_F00D, 32'h1234_5678}, 0, 0);
        check("t042_data", mem_wr_data, 512'hCAFE_F00D);
        cycle(0, 0, '0, 1, 0);

        // idle beats in COLLECT
        cycle(1, 64, hdr(64, 40'h66), 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 0, 0);
`ifdef IPG_WREQ_TIMEOUT_EN
        check("t043_busy", busy, 0);
`else
        check("t043_busy", busy, 1);
`endif
        cycle(0, 0, '0, 0, 0);
        check("t043_nowrite", mem_wr_valid, 0);
        cycle(0, 0, '0, 0, 1);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            rd   = {$urandom, $urandom};
            rv   = ($urandom_range(0, 9) < 7);
            rrdy = $urandom_range(0, 1) == 1;
            rrst = ($urandom_range(0, 199) == 0);
            rl   = $urandom_range(0, 80);
            if (m_mode == 0 && $urandom_range(0, 9) < 8) begin
                rl = $urandom_range(56, 90);
                rd[DW-1 -: HW] = ($urandom_range(0, 9) == 0) ? HW'($urandom_range(0, 700))
                                                             : HW'($urandom_range(1, 200));
            end
            cycle(rv, rl, rd, rrdy, rrst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
